// File: rtl/fetch_stage_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned FETCH_XLEN  = 32;
    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_prefetch_buffer.sv
// Prefetch FIFO holding fetched {pc, instr} entries; flush takes priority over push.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t         mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_i && !pop_i) count_d = count_q + 1'b1;
            if (!push_i && pop_i) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst)
        (push_i && !flush_i) |-> (!full_o || pop_i));

endmodule

// File: rtl/fetch_stage_prefetch.sv
// Fetch stage with credit-based prefetch buffer and redirect drop accounting.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_p_4,
    output logic [31:0]     o_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     o_perf_fetched,
    output logic [31:0]     o_perf_dropped,
    output logic [31:0]     o_perf_starve
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(DEPTH + MAX_OUTSTANDING + 1);
    localparam int unsigned FW = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   drop_q, drop_d;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   credits_used;
    logic [FW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic            req, grant, push, pop;
    entry_t          push_entry, head;

    always_comb begin
        redirect_pc  = i_redirect_pc & ~XLEN'(3);
        // Slots already promised: buffered entries plus in-flight responses that will be kept.
        credits_used = CW'(fifo_count) + CW'(outst_q) - CW'(drop_q);
        req   = i_rst && !i_redirect && (outst_q < OW'(MAX_OUTSTANDING))
                && (credits_used < CW'(DEPTH));
        grant = req && i_imem_gnt;
        push  = i_imem_rvalid && (drop_q == '0) && !i_redirect;
        o_valid = !fifo_empty && !i_redirect;
        pop   = o_valid && i_ready;
        push_entry = '{pc: rsp_pc_q, instr: i_imem_rdata};

        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        outst_d    = outst_q + OW'(grant) - OW'(i_imem_rvalid);
        if (i_redirect) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_d     = outst_q - OW'(i_imem_rvalid);
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + PC_STEP;
            if (i_imem_rvalid && (drop_q != '0)) drop_d = drop_q - 1'b1;
            if (push) rsp_pc_d = rsp_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_buffer #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_buffer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (i_redirect),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign o_imem_req  = req;
    assign o_imem_addr = fetch_pc_q;
    assign o_pc        = head.pc;
    assign o_pc_p_4    = head.pc + PC_STEP;
    assign o_instr     = head.instr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_dropped_q, perf_starve_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
            perf_starve_q  <= '0;
        end else begin
            if (push && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
            if (i_imem_rvalid && !push && (perf_dropped_q != '1))
                perf_dropped_q <= perf_dropped_q + 32'd1;
            if (i_ready && !o_valid && (perf_starve_q != '1))
                perf_starve_q <= perf_starve_q + 32'd1;
        end
    end

    assign o_perf_fetched = perf_fetched_q;
    assign o_perf_dropped = perf_dropped_q;
    assign o_perf_starve  = perf_starve_q;
`endif

    a_outst_max: assert property (@(posedge i_clk) disable iff (!i_rst)
        outst_q <= OW'(MAX_OUTSTANDING));
    a_drop_le_outst: assert property (@(posedge i_clk) disable iff (!i_rst)
        drop_q <= outst_q);
    a_push_room: assert property (@(posedge i_clk) disable iff (!i_rst)
        push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_fetch_stage_prefetch.sv
// Scoreboard bench for fetch_stage_prefetch with an in-order variable-latency memory model.
`timescale 1ns/1ps
module tb_fetch_stage_prefetch;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_pc, o_pc_p_4, o_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_perf_fetched, o_perf_dropped, o_perf_starve;
`endif

    always #5 i_clk = ~i_clk;

    fetch_stage_prefetch #(
        .XLEN            (32),
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_pc          (o_pc),
        .o_pc_p_4      (o_pc_p_4),
        .o_instr       (o_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_fetched (o_perf_fetched),
        .o_perf_dropped (o_perf_dropped),
        .o_perf_starve  (o_perf_starve)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0, mem_lat = 1, grants = 0, outst = 0, max_outst = 0;
    bit          want_ready = 1'b0;
    bit          g_prev = 1'b0;
    logic [31:0] a_prev = '0;
    logic [31:0] mon_e;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h13A5_5A13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory model: responses in grant order, mem_lat cycles after the granting edge.
    always @(posedge i_clk) begin
        #1;
        cyc++;
        if (!i_rst) begin
            pend.delete();
            i_imem_rvalid = 1'b0;
        end else begin
            if (i_imem_rvalid && pend.size() != 0) void'(pend.pop_front());
            if (g_prev) pend.push_back('{addr: a_prev, due: cyc + mem_lat - 1});
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = instr_of(pend[0].addr);
            end else begin
                i_imem_rvalid = 1'b0;
            end
        end
    end

    // Monitor: protocol sampling, address scoreboard and decode-side scoreboard.
    always @(negedge i_clk) begin
        g_prev = o_imem_req && i_imem_gnt;
        a_prev = o_imem_addr;
        if (!i_rst) begin
            grants = 0; outst = 0; max_outst = 0;
        end else begin
            if (g_prev) begin grants++; outst++; end
            if (i_imem_rvalid) outst--;
            if (outst > max_outst) max_outst = outst;
            if (g_prev && addr_q.size() != 0) chk("imem_addr", o_imem_addr, addr_q.pop_front());
        end
        i_ready = want_ready && (exp_q.size() != 0);
        if (o_valid && i_ready) begin
            mon_e = exp_q.pop_front();
            chk("o_pc", o_pc, mon_e);
            chk("o_pc_p_4", o_pc_p_4, 32'(mon_e + 32'd4));
            chk("o_instr", o_instr, instr_of(mon_e));
        end
    end

    task automatic do_reset();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        i_redirect = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        chk(name, 32'(exp_q.size() + addr_q.size()), 32'd0);
    endtask

    task automatic wait_grants(input string name, input int unsigned target);
        int unsigned n = 0;
        while (grants < target && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk(name, grants, target);
    endtask

    initial begin
        // Zero-wait memory, decode always ready.
        mem_lat = 1; i_imem_gnt = 1'b1; want_ready = 1'b1;
        do_reset();
        for (int unsigned i = 0; i < 8; i++) begin
            exp_q.push_back(32'(i * 4));
            addr_q.push_back(32'(i * 4));
        end
        @(negedge i_clk); chk("t1_valid_c1", 32'(o_valid), 32'd0);
        @(negedge i_clk); chk("t1_valid_c2", 32'(o_valid), 32'd0);
        @(negedge i_clk); chk("t1_valid_c3", 32'(o_valid), 32'd1);
        chk("t1_pc_c3", o_pc, 32'h0);
        wait_drain("t1_drain");

        // Decode stalled: buffer fills to DEPTH then requests stop.
        want_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge i_clk);
        chk("t2_grants", grants, 32'd4);
        chk("t2_req_off", 32'(o_imem_req), 32'd0);
        chk("t2_valid", 32'(o_valid), 32'd1);
        chk("t2_head", o_pc, 32'h0);
        for (int unsigned i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        addr_q.push_back(32'd16);
        addr_q.push_back(32'd20);
        want_ready = 1'b1;
        wait_drain("t2_drain");

        // Three-cycle memory latency: at most two requests in flight.
        mem_lat = 3;
        do_reset();
        for (int unsigned i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        @(negedge i_clk); chk("t3_req_c1", 32'(o_imem_req), 32'd1);
        @(negedge i_clk); chk("t3_req_c2", 32'(o_imem_req), 32'd1);
        @(negedge i_clk); chk("t3_req_c3", 32'(o_imem_req), 32'd0);
        @(negedge i_clk); chk("t3_req_c4", 32'(o_imem_req), 32'd0);
        chk("t3_rvalid_c4", 32'(i_imem_rvalid), 32'd1);
        @(negedge i_clk); chk("t3_req_c5", 32'(o_imem_req), 32'd1);
        wait_drain("t3_drain");
        chk("t3_max_outst", max_outst, 32'd2);

        // Redirect while PCs 8 and 12 are outstanding.
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        for (int unsigned i = 0; i < 4; i++) addr_q.push_back(32'(i * 4));
        wait_grants("t4_sync", 4);
        chk("t4_outst", outst, 32'd2);
        i_redirect = 1'b1; i_redirect_pc = 32'h0000_0100;
        for (int unsigned i = 0; i < 3; i++) exp_q.push_back(32'(32'h100 + i * 4));
        addr_q.push_back(32'h100); addr_q.push_back(32'h104);
        @(negedge i_clk);
        chk("t4_valid_redir", 32'(o_valid), 32'd0);
        chk("t4_req_redir", 32'(o_imem_req), 32'd0);
        @(posedge i_clk); #1; i_redirect = 1'b0;
        wait_drain("t4_drain");
`ifdef FETCH_PERF_CNT_EN
        chk("t4_perf_dropped", o_perf_dropped, 32'd2);
`endif

        // Redirect coinciding with a response and a nearly full buffer.
        mem_lat = 1; want_ready = 1'b0;
        do_reset();
        wait_grants("t5_sync", 4);
        i_redirect = 1'b1; i_redirect_pc = 32'h0000_0200;
        @(negedge i_clk);
        chk("t5_rvalid", 32'(i_imem_rvalid), 32'd1);
        chk("t5_valid_redir", 32'(o_valid), 32'd0);
        chk("t5_req_redir", 32'(o_imem_req), 32'd0);
        for (int unsigned i = 0; i < 4; i++) exp_q.push_back(32'(32'h200 + i * 4));
        want_ready = 1'b1;
        @(posedge i_clk); #1; i_redirect = 1'b0;
        wait_drain("t5_drain");
`ifdef FETCH_PERF_CNT_EN
        chk("t5_perf_dropped", o_perf_dropped, 32'd1);
`endif

        // Misaligned redirect near the top of the address space, with grant stall.
        want_ready = 1'b0;
        do_reset();
        repeat (8) @(negedge i_clk);
        @(posedge i_clk); #1;
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFE; i_imem_gnt = 1'b0;
        addr_q.push_back(32'hFFFF_FFFC);
        @(posedge i_clk); #1; i_redirect = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("t6_hold_req", 32'(o_imem_req), 32'd1);
            chk("t6_hold_addr", o_imem_addr, 32'hFFFF_FFFC);
        end
        @(posedge i_clk); #1; i_imem_gnt = 1'b1;
        addr_q.push_back(32'h0);
        exp_q.push_back(32'hFFFF_FFFC);
        for (int unsigned i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
        want_ready = 1'b1;
        wait_drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_stage_prefetch.md
Name: fetch_stage_prefetch

Overview:
Parametrised instruction-fetch stage with a prefetch buffer. It decouples the PC generator from instruction memory through a req/gnt/rvalid handshake that tolerates multi-cycle, pipelined memory latency. Fetched {pc, instr} pairs are buffered in a FIFO and handed to decode with a valid/ready handshake. Sits between the exec-stage redirect source and the decode stage; hazard stalls are expressed as i_ready=0 from decode.

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max granted-but-unanswered memory requests (1..DEPTH)
RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
i_redirect  in  1  branch/jump taken from exec; flush and reload PC
i_redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
o_imem_req  out  1  request valid
o_imem_addr  out  XLEN  request word address (= fetch PC)
i_imem_gnt  in  1  request accepted this cycle
i_imem_rvalid  in  1  response valid; responses return in request order, earliest 1 cycle after grant
i_imem_rdata  in  32  response instruction
o_valid  out  1  decode entry valid
i_ready  in  1  decode accepts entry
o_pc  out  XLEN  PC of head entry
o_pc_p_4  out  XLEN  o_pc + 4
o_instr  out  32  instruction of head entry

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = rsp_pc = RESET_PC; FIFO empty; outstanding_cnt = drop_cnt = 0.
  - o_valid = 0, o_imem_req = 0 (forced low while i_rst low); o_pc/o_instr = 0.
- Request rule: o_imem_req = !i_redirect && outstanding_cnt < MAX_OUTSTANDING && (fifo_count + outstanding_cnt - drop_cnt) < DEPTH. Credits guarantee every kept response has a FIFO slot; no backpressure on responses.
- Grant (req && gnt): fetch_pc += 4; outstanding_cnt++. o_imem_addr must be held stable while req is high and not granted.
- Response (rvalid): outstanding_cnt--.
  - If drop_cnt > 0: discard, drop_cnt--.
  - Else push {rsp_pc, rdata}; rsp_pc += 4.
  - Grant and response in the same cycle leave outstanding_cnt unchanged.
- Output: o_valid = !fifo_empty && !i_redirect; head fields are registered FIFO outputs. Pop on o_valid && i_ready. Minimum latency rvalid -> o_valid is 1 cycle (no bypass). With a zero-wait memory (gnt=1, rvalid next cycle), the first o_valid occurs in the 3rd cycle after reset release.
- Redirect (highest priority, single cycle):
  - fetch_pc = rsp_pc = {i_redirect_pc[XLEN-1:2], 2'b00}; FIFO cleared; no pop.
  - drop_cnt = outstanding_cnt - (rvalid ? 1 : 0). A same-cycle response is discarded and needs no drop accounting.
  - No grant is possible in a redirect cycle (req low). First request to the new PC is issued the next cycle.
  - A back-to-back redirect recomputes drop_cnt from the current outstanding_cnt.
- Boundaries:
  - Simultaneous push and pop on a full FIFO: legal.
  - Pop from an empty FIFO: never (o_valid=0).
  - PC arithmetic wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
  - Asserting i_rst mid-transaction drops all state; the memory is required to share the same reset.
- Assertions: outstanding_cnt <= MAX_OUTSTANDING; drop_cnt <= outstanding_cnt; no push when full.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs o_perf_fetched (32, kept responses pushed), o_perf_dropped (32, responses discarded), o_perf_starve (32, cycles with i_ready=1 && o_valid=0). All reset to 0 and saturate at 2^32-1.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg: fetch_entry_t {logic [XLEN-1:0] pc; logic [31:0] instr;}, INSTR_BYTES = 4, default RESET_PC.
- Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t with DEPTH, push/pop/flush, full/empty/count. Flush has priority over push.
- Top holds the PC, credit counters and drop logic.

Test Plan:
- Zero-wait memory, i_ready=1, reset release: addrs 0,4,8,... one per cycle; o_pc 0,4,8 consecutive from the 3rd cycle; o_pc_p_4 = o_pc+4.
- Decode stalled (i_ready=0), DEPTH=4: exactly 4 entries buffered, then o_imem_req=0; release i_ready -> 0,4,8,12 delivered in order, fetch resumes at 16.
- Memory with 3-cycle response latency, MAX_OUTSTANDING=2: at most 2 grants unanswered; req drops after 2nd grant until first rvalid.
- Redirect to 0x100 with 2 outstanding (PCs 8,12): both responses discarded, FIFO empty, next o_valid has o_pc=0x100; o_perf_dropped += 2 if enabled.
- Redirect coinciding with rvalid and a full FIFO: no entry delivered that cycle, drop_cnt = outstanding-1, first delivered PC is the target.
- Redirect to 0xFFFF_FFFE: fetch at 0xFFFF_FFFC, then wraps to 0x0000_0000.
